// File: rtl/lane_bank_driver.sv
// Lane bank driver: latches an accepted word into bank A or B (FILL on the other), drives it
// until the receiver handshakes, then idles HOLD_CYCLES cycles. BANK_PARITY_EN adds output par.
module lane_bank_driver #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [7:0]  FILL        = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_bank,
  output logic       sel,
  output logic [7:0] bank_a,
  output logic [7:0] bank_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] exp_flag,
  output logic       exp_sum,
  output logic [7:0] txn_count
`ifdef BANK_PARITY_EN
  ,
  output logic       par
`endif
);

  typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

  localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES);

  state_e     state_q;
  logic [3:0] hold_cnt_q;
  logic [3:0] flag_d;
  logic       sum_d;

  // Predicted receiver response: per-pair NOR, then the summary gate.
  always_comb begin
    flag_d = '0;
    for (int i = 0; i < 4; i++) begin
      flag_d[i] = ~|in_data[2*i +: 2];
    end
    sum_d = ~((flag_d[0] | flag_d[1]) & (flag_d[2] | flag_d[3]));
  end

  assign in_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_cnt_q <= 4'd0;
      sel        <= 1'b0;
      bank_a     <= 8'h00;
      bank_b     <= 8'h00;
      out_valid  <= 1'b0;
      exp_flag   <= 4'h0;
      exp_sum    <= 1'b1;
      txn_count  <= 8'h00;
`ifdef BANK_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            bank_a    <= in_bank ? FILL : in_data;
            bank_b    <= in_bank ? in_data : FILL;
            sel       <= in_bank;
            exp_flag  <= flag_d;
            exp_sum   <= sum_d;
            out_valid <= 1'b1;
`ifdef BANK_PARITY_EN
            par       <= ^in_data;
`endif
            state_q   <= StDrive;
          end
        end
        StDrive: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            txn_count  <= txn_count + 8'd1;
            hold_cnt_q <= HoldLoad;
            state_q    <= (HOLD_CYCLES == 0) ? StIdle : StHold;
          end
        end
        StHold: begin
          hold_cnt_q <= hold_cnt_q - 4'd1;
          // Leave on the edge where the counter reaches zero.
          if (hold_cnt_q <= 4'd1) begin
            hold_cnt_q <= 4'd0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_bank_driver.sv
// Directed bench for lane_bank_driver: vector table plus multi-cycle sequences
// (stall, hold timing, counter wrap, mid-drive reset).
module tb_lane_bank_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_bank;
  logic       sel;
  logic [7:0] bank_a;
  logic [7:0] bank_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] exp_flag;
  logic       exp_sum;
  logic [7:0] txn_count;
`ifdef BANK_PARITY_EN
  logic       par;
`endif

  lane_bank_driver #(
    .HOLD_CYCLES(2),
    .FILL       (8'hFF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_bank  (in_bank),
    .sel      (sel),
    .bank_a   (bank_a),
    .bank_b   (bank_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .exp_flag (exp_flag),
    .exp_sum  (exp_sum),
    .txn_count(txn_count)
`ifdef BANK_PARITY_EN
    ,
    .par      (par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       bank;
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic [3:0] flag;
    logic       sum;
    logic       par;
  } vec_t;

  vec_t vecs[8];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_txn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every sample and drive happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic deliver(input logic [7:0] d, input logic b);
    wait_ready();
    in_valid  = 1'b1;
    in_data   = d;
    in_bank   = b;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    //             data   bank a      b      sel   flag   sum   par
    vecs[0] = '{8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 8'hFF, 8'hA5, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 1'b0, 8'h0F, 8'hFF, 1'b0, 4'hC, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 8'hFF, 8'h3C, 1'b1, 4'h9, 1'b0, 1'b0};
    vecs[4] = '{8'h40, 1'b0, 8'h40, 8'hFF, 1'b0, 4'h7, 1'b0, 1'b1};
    vecs[5] = '{8'h02, 1'b1, 8'hFF, 8'h02, 1'b1, 4'hE, 1'b0, 1'b1};
    vecs[6] = '{8'h81, 1'b1, 8'hFF, 8'h81, 1'b1, 4'h6, 1'b0, 1'b0};
    vecs[7] = '{8'h50, 1'b0, 8'h50, 8'hFF, 1'b0, 4'h3, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_bank = 1'b0; out_ready = 1'b0;
    exp_txn = 8'd0;
    tick();
    tick();
    check("rst_bank_a", {24'd0, bank_a}, 32'h00);
    check("rst_bank_b", {24'd0, bank_b}, 32'h00);
    check("rst_sel", {31'd0, sel}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_exp_flag", {28'd0, exp_flag}, 32'h0);
    check("rst_exp_sum", {31'd0, exp_sum}, 32'd1);
    check("rst_txn_count", {24'd0, txn_count}, 32'd0);
`ifdef BANK_PARITY_EN
    check("rst_par", {31'd0, par}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table: accept, check latched drive, handshake, check count.
    for (int i = 0; i < 8; i++) begin
      wait_ready();
      in_valid = 1'b1; in_data = vecs[i].data; in_bank = vecs[i].bank; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; in_data = ~vecs[i].data; in_bank = ~vecs[i].bank;
      check($sformatf("v%0d_bank_a", i), {24'd0, bank_a}, {24'd0, vecs[i].a});
      check($sformatf("v%0d_bank_b", i), {24'd0, bank_b}, {24'd0, vecs[i].b});
      check($sformatf("v%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].sel});
      check($sformatf("v%0d_flag", i), {28'd0, exp_flag}, {28'd0, vecs[i].flag});
      check($sformatf("v%0d_sum", i), {31'd0, exp_sum}, {31'd0, vecs[i].sum});
      check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
`ifdef BANK_PARITY_EN
      check($sformatf("v%0d_par", i), {31'd0, par}, {31'd0, vecs[i].par});
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_txn++;
      check($sformatf("v%0d_hs_out_valid", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("v%0d_txn_count", i), {24'd0, txn_count}, {24'd0, exp_txn});
      check($sformatf("v%0d_hold_bank_a", i), {24'd0, bank_a}, {24'd0, vecs[i].a});
    end

    // Stall: receiver not ready for 5 cycles; new words on in_valid are ignored.
    wait_ready();
    in_valid = 1'b1; in_data = 8'hA5; in_bank = 1'b1;
    tick();
    in_data = 8'h3C; in_bank = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("stall%0d_bank_b", k), {24'd0, bank_b}, 32'hA5);
      tick();
    end
    check("stall_flag", {28'd0, exp_flag}, 32'h0);
    check("stall_sum", {31'd0, exp_sum}, 32'd1);
    check("stall_txn_count", {24'd0, txn_count}, {24'd0, exp_txn});
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_txn++;
    check("stall_hs_txn_count", {24'd0, txn_count}, {24'd0, exp_txn});

    // Hold timing with in_valid held high: in_ready is back in the 3rd cycle after handshake.
    wait_ready();
    in_valid = 1'b1; in_data = 8'h11; in_bank = 1'b0; out_ready = 1'b1;
    tick();
    check("b2b_first_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    exp_txn++;
    out_ready = 1'b0;
    in_data = 8'h22;
    check("b2b_hs_in_ready_c1", {31'd0, in_ready}, 32'd0);
    check("b2b_hs_txn_count", {24'd0, txn_count}, {24'd0, exp_txn});
    tick();
    check("b2b_in_ready_c2", {31'd0, in_ready}, 32'd0);
    tick();
    check("b2b_in_ready_c3", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_second_out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_second_bank_a", {24'd0, bank_a}, 32'h22);

    // Reset asserted mid-drive with out_ready high: immediate reset values, no count.
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_bank_a", {24'd0, bank_a}, 32'h00);
    check("arst_bank_b", {24'd0, bank_b}, 32'h00);
    check("arst_sel", {31'd0, sel}, 32'd0);
    check("arst_flag", {28'd0, exp_flag}, 32'h0);
    check("arst_sum", {31'd0, exp_sum}, 32'd1);
    check("arst_txn_count", {24'd0, txn_count}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    tick();
    check("arst_rel_txn_count", {24'd0, txn_count}, 32'd0);
    check("arst_rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Counter wrap after 256 deliveries.
    for (int i = 0; i < 256; i++) begin
      deliver(8'(i), 1'(i));
      if (i == 254) check("wrap_txn_255", {24'd0, txn_count}, 32'd255);
    end
    check("wrap_txn_0", {24'd0, txn_count}, 32'd0);

`ifdef BANK_PARITY_EN
    wait_ready();
    in_valid = 1'b1; in_data = 8'h07; in_bank = 1'b0;
    tick();
    in_valid = 1'b0;
    check("par_07", {31'd0, par}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
